tri_fir_smoother: RTL and testbench

TRI_FIR_SMOOTHER -- requirements
Module: tri_fir_smoother

---
 rtl/tri_fir_pkg.sv | 26 ++
 rtl/tri_fir_mac.sv | 23 ++
 rtl/tri_fir_smoother.sv | 159 +++++++++++++++
 tb/tb_tri_fir_smoother.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/tri_fir_pkg.sv
// Shared types and helpers for the triangular FIR smoother.
// The coefficient and width helpers are constant functions, so they can be
// used in parameter defaults and in elaboration-time loops.
package tri_fir_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StFlush = 2'd2
  } tri_fir_state_e;

  // Triangular weight of tap k for half-length h: 1, 2, .., h+1, .., 2, 1.
  function automatic int unsigned tri_fir_coef(input int unsigned k, input int unsigned h);
    int unsigned up;
    int unsigned down;
    up   = k + 1;
    down = 2 * h + 1 - k;
    return (up < down) ? up : down;
  endfunction

  // Width that holds the full-precision weighted sum; the weights add up to (h+1)^2.
  function automatic int unsigned tri_fir_sum_w(input int unsigned data_w, input int unsigned h);
    return data_w + $clog2((h + 1) * (h + 1));
  endfunction

endpackage

// File: rtl/tri_fir_mac.sv
// Combinational triangular-weighted sum of all window taps.
module tri_fir_mac
  import tri_fir_pkg::*;
#(
  parameter int unsigned DATA_W   = 10,
  parameter int unsigned HALF_LEN = 7,
  parameter int unsigned SUM_W    = tri_fir_sum_w(DATA_W, HALF_LEN)
) (
  input  logic [DATA_W-1:0] win_i [2*HALF_LEN+1],
  output logic [SUM_W-1:0]  sum_o
);

  localparam int unsigned Taps = 2 * HALF_LEN + 1;

  // Weighted sum; coefficients are constants, so each term becomes a shift-add.
  always_comb begin
    sum_o = '0;
    for (int unsigned k = 0; k < Taps; k++) begin
      sum_o = sum_o + SUM_W'(tri_fir_coef(k, HALF_LEN)) * SUM_W'(win_i[k]);
    end
  end

endmodule

// File: rtl/tri_fir_smoother.sv
// Streaming triangular FIR smoother with edge replication at frame boundaries.
// Each frame of N samples yields exactly N outputs. Optional build macro
// TRI_FIR_NORM_EN divides the sum by the kernel gain (rounded) and narrows
// out_data to DATA_W bits.
module tri_fir_smoother
  import tri_fir_pkg::*;
#(
  parameter int unsigned DATA_W   = 10,
  parameter int unsigned HALF_LEN = 7,
  parameter int unsigned SUM_W    = tri_fir_sum_w(DATA_W, HALF_LEN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef TRI_FIR_NORM_EN
  output logic [DATA_W-1:0] out_data,
`else
  output logic [SUM_W-1:0]  out_data,
`endif
  output logic              out_last
);

  localparam int unsigned Taps = 2 * HALF_LEN + 1;
  localparam int unsigned CntW = (HALF_LEN < 2) ? 1 : $clog2(HALF_LEN + 1);
`ifdef TRI_FIR_NORM_EN
  localparam int unsigned OutW  = DATA_W;
  localparam int unsigned NormS = 2 * $clog2(HALF_LEN + 1);
  if ((1 << $clog2(HALF_LEN + 1)) != HALF_LEN + 1) begin : g_bad_half_len
    $error("tri_fir_smoother: HALF_LEN+1 must be a power of two when normalising");
  end
`else
  localparam int unsigned OutW = SUM_W;
`endif

  tri_fir_state_e    state_q, state_d;
  logic [CntW-1:0]   s_q, s_d;        // shifts since load, saturating at HALF_LEN
  logic [CntW-1:0]   f_q, f_d;        // flush shifts done
  logic [DATA_W-1:0] win_q [Taps];
  logic [DATA_W-1:0] win_d [Taps];
  logic              out_valid_q, out_valid_d;
  logic [OutW-1:0]   out_data_q, out_data_d;
  logic              out_last_q, out_last_d;

  logic              stall, accept, do_shift, produce, last_shift;
  logic [DATA_W-1:0] shift_in;
  logic [SUM_W-1:0]  sum_post;

  // The output register captures the sum of the post-shift window.
  tri_fir_mac #(
    .DATA_W  (DATA_W),
    .HALF_LEN(HALF_LEN),
    .SUM_W   (SUM_W)
  ) u_mac (
    .win_i(win_d),
    .sum_o(sum_post)
  );

  // Next-state: handshake, FSM, window update and output register load.
  always_comb begin
    stall      = out_valid_q & ~out_ready;
    in_ready   = ~reset & (state_q != StFlush) & ~stall;
    accept     = in_valid & in_ready;
    state_d    = state_q;
    s_d        = s_q;
    f_d        = f_q;
    win_d      = win_q;
    do_shift   = 1'b0;
    last_shift = 1'b0;
    shift_in   = in_data;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          // First sample fills the whole window, replicating x0 to the left.
          for (int k = 0; k < Taps; k++) win_d[k] = in_data;
          s_d     = '0;
          f_d     = '0;
          state_d = in_last ? StFlush : StRun;
        end
      end
      StRun: begin
        if (accept) begin
          do_shift = 1'b1;
          if (in_last) begin
            f_d     = '0;
            state_d = StFlush;
          end
        end
      end
      StFlush: begin
        if (!stall) begin
          // Replicate the newest sample (x[N-1]) to the right.
          do_shift = 1'b1;
          shift_in = win_q[Taps-1];
          f_d      = f_q + 1'b1;
          if (f_q == CntW'(HALF_LEN - 1)) begin
            last_shift = 1'b1;
            state_d    = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (do_shift) begin
      for (int k = 0; k < Taps - 1; k++) win_d[k] = win_q[k+1];
      win_d[Taps-1] = shift_in;
      s_d = (s_q == CntW'(HALF_LEN)) ? s_q : s_q + 1'b1;
    end
    produce = do_shift & (s_d == CntW'(HALF_LEN));

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (produce) begin
      out_valid_d = 1'b1;
`ifdef TRI_FIR_NORM_EN
      out_data_d  = OutW'((sum_post + (SUM_W'(1) << (NormS - 1))) >> NormS);
`else
      out_data_d  = sum_post;
`endif
      out_last_d  = last_shift;
    end else if (!stall) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      s_q         <= '0;
      f_q         <= '0;
      win_q       <= '{default: '0};
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      f_q         <= f_d;
      win_q       <= win_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_tri_fir_smoother.sv
// Directed bench for tri_fir_smoother: frames are streamed through the DUT,
// outputs are collected per frame, then checked against a table of
// hand-computed values and an independent clamp-based reference.
module tb_tri_fir_smoother;
  localparam int DATA_W = 10;
  localparam int H      = 7;
  localparam int T      = 2 * H + 1;
  localparam int SUM_W  = 16;
`ifdef TRI_FIR_NORM_EN
  localparam int OUT_W  = DATA_W;
`else
  localparam int OUT_W  = SUM_W;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid, in_ready, in_last;
  logic [DATA_W-1:0] in_data;
  logic              out_valid, out_ready, out_last;
  logic [OUT_W-1:0]  out_data;

  tri_fir_smoother #(
    .DATA_W  (DATA_W),
    .HALF_LEN(H),
    .SUM_W   (SUM_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int fid;
    int idx;
    int raw;
    bit last;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  int   x [64];
  int   res_data [8][64];
  bit   res_last [8][64];
  int   res_cnt [8];
  int   flush_low [8];
  vec_t tbl [$];

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int nrm(input int v);
`ifdef TRI_FIR_NORM_EN
    return (v + (1 << (2 * $clog2(H + 1) - 1))) >> (2 * $clog2(H + 1));
`else
    return v;
`endif
  endfunction

  // Reference: direct formula with index clamping at both frame edges.
  function automatic int model(input int i, input int n);
    int acc = 0;
    for (int k = 0; k < T; k++) begin
      int j = i + k - H;
      int c = (k + 1 < T - k) ? k + 1 : T - k;
      if (j < 0) j = 0;
      if (j > n - 1) j = n - 1;
      acc += c * x[j];
    end
    return nrm(acc);
  endfunction

  // Streams one frame and collects its outputs. abort_after >= 0 stops after
  // that many samples have been accepted (used for the mid-frame reset).
  task automatic run_frame(input int fid, input int n, input int stall_at, input int stall_len,
                           input int abort_after);
    int idx = 0;
    int cyc = 0;
    bit done = 0;
    bit prev_stall = 0;
    logic [OUT_W-1:0] held_data = '0;
    logic held_last = 0;
    res_cnt[fid]   = 0;
    flush_low[fid] = 0;
    while (cyc < 600) begin
      bit stalled;
      @(negedge clk);
      in_valid  = (idx < n) && (abort_after < 0 || idx < abort_after);
      in_data   = DATA_W'(x[(idx < 64) ? idx : 63]);
      in_last   = (idx == n - 1);
      out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      #1;
      stalled = out_valid && !out_ready;
      if (stalled) chk("stall_in_ready", in_ready, 0);
      if (stalled && prev_stall) begin
        chk("stall_hold_data", out_data, int'(held_data));
        chk("stall_hold_last", out_last, int'(held_last));
      end
      if (idx == n && !stalled && !in_ready) flush_low[fid]++;
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin
        if (res_cnt[fid] < 64) begin
          res_data[fid][res_cnt[fid]] = int'(out_data);
          res_last[fid][res_cnt[fid]] = out_last;
        end
        res_cnt[fid]++;
      end
      prev_stall = stalled;
      held_data  = out_data;
      held_last  = out_last;
      cyc++;
      if (abort_after >= 0 && idx == abort_after) begin
        done = 1;
        break;
      end
      if (res_cnt[fid] == n) begin
        done = 1;
        break;
      end
    end
    if (!done) chk("frame_timeout", 1, 0);
    @(negedge clk);
    in_valid  = 0;
    in_last   = 0;
    out_ready = 1;
  endtask

  initial begin
    // Hand-computed expectations (raw sums; normalised by nrm when enabled).
    tbl.push_back('{0, 0, 6400, 1'b0});
    tbl.push_back('{0, 10, 6400, 1'b0});
    tbl.push_back('{0, 19, 6400, 1'b1});
    tbl.push_back('{1, 8, 0, 1'b0});
    tbl.push_back('{1, 9, 1, 1'b0});
    tbl.push_back('{1, 12, 4, 1'b0});
    tbl.push_back('{1, 16, 8, 1'b0});
    tbl.push_back('{1, 20, 4, 1'b0});
    tbl.push_back('{1, 23, 1, 1'b0});
    tbl.push_back('{1, 24, 0, 1'b0});
    tbl.push_back('{1, 31, 0, 1'b1});
    tbl.push_back('{2, 0, 36828, 1'b0});
    tbl.push_back('{2, 1, 28644, 1'b0});
    tbl.push_back('{2, 7, 1023, 1'b0});
    tbl.push_back('{2, 8, 0, 1'b0});
    tbl.push_back('{2, 9, 0, 1'b1});
    tbl.push_back('{3, 0, 320, 1'b1});
    tbl.push_back('{6, 0, 36828, 1'b0});
    tbl.push_back('{6, 1, 28644, 1'b0});
    tbl.push_back('{6, 9, 0, 1'b1});

    reset     = 1;
    in_valid  = 0;
    in_data   = '0;
    in_last   = 0;
    out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_last", out_last, 0);
    chk("reset_in_ready", in_ready, 0);
    @(negedge clk);
    reset = 0;

    // Frame 0: constant 100, N=20.
    foreach (x[i]) x[i] = 100;
    run_frame(0, 20, 1000, 0, -1);
    // Frame 1: impulse at x16, N=32.
    foreach (x[i]) x[i] = (i == 16) ? 1 : 0;
    run_frame(1, 32, 1000, 0, -1);
    // Frame 2: left-edge step, N=10.
    foreach (x[i]) x[i] = (i == 0) ? 1023 : 0;
    run_frame(2, 10, 1000, 0, -1);
    // Frame 3: single-sample frame.
    foreach (x[i]) x[i] = 5;
    run_frame(3, 1, 1000, 0, -1);
    chk("n1_flush_in_ready_low", flush_low[3], H);
    chk("n20_flush_in_ready_low", flush_low[0], H);

    // Frames 4/5: ramp, unstalled then with a 5-cycle output stall.
    foreach (x[i]) x[i] = (i * 37 + 11) % 1024;
    run_frame(4, 16, 1000, 0, -1);
    for (int i = 0; i < 16; i++) chk($sformatf("ramp_model[%0d]", i), res_data[4][i], model(i, 16));
    run_frame(5, 16, 12, 5, -1);
    chk("stall_count", res_cnt[5], 16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("stall_vs_free[%0d]", i), res_data[5][i], res_data[4][i]);
      chk($sformatf("stall_last[%0d]", i), res_last[5][i], (i == 15) ? 1 : 0);
    end

    // Mid-frame reset, then a full frame must be processed cleanly.
    foreach (x[i]) x[i] = 300;
    run_frame(7, 20, 1000, 0, 12);
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    #1;
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_out_data", out_data, 0);
    chk("midreset_in_ready", in_ready, 0);
    @(negedge clk);
    reset = 0;
    foreach (x[i]) x[i] = (i == 0) ? 1023 : 0;
    run_frame(6, 10, 1000, 0, -1);
    for (int i = 0; i < 10; i++) chk($sformatf("post_reset_model[%0d]", i), res_data[6][i], model(i, 10));

    chk("count_f0", res_cnt[0], 20);
    chk("count_f1", res_cnt[1], 32);
    chk("count_f2", res_cnt[2], 10);
    chk("count_f3", res_cnt[3], 1);
    for (int i = 0; i < 19; i++) chk($sformatf("const_last[%0d]", i), res_last[0][i], 0);

    foreach (tbl[v]) begin
      chk($sformatf("tbl_data f%0d[%0d]", tbl[v].fid, tbl[v].idx),
          res_data[tbl[v].fid][tbl[v].idx], nrm(tbl[v].raw));
      chk($sformatf("tbl_last f%0d[%0d]", tbl[v].fid, tbl[v].idx),
          res_last[tbl[v].fid][tbl[v].idx], int'(tbl[v].last));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
